iic_reg_bank: RTL and testbench
===============================

// Module: iic_reg_bank
// PURPOSE
//  Register bank directly downstream of the IIC slave front end. Consumes its writeEn/regAddr/dataOut
//  strobes, commits byte writes into control registers, and returns read data on rd_data (drives slave dataIn).
//  Also holds IRQ flag/mask logic and a 16-bit event counter with an atomic two-byte read.
// PARAMETERS
//  NUM_CTRL    8      number of RW control registers at 0x00..NUM_CTRL-1 (1..16)
//  CTRL_RST    8'h00  reset value of every control register
//  ID_VALUE    8'h5A  constant returned at address 0x1F
// PORTS
//  clk        in   1           system clock
//  rst_n      in   1           asynchronous active-low reset
//  iic_en     in   1           slave transaction active; qualifies reads and writes
//  writeEn    in   1           slave write request (level, may be held several cycles)
//  readEn     in   1           slave read request (level)
//  regAddr    in   8           register address from slave
//  wr_data    in   8           write byte (slave dataOut)
//  rd_data    out  8           registered read byte (slave dataIn)
//  ctrl_o     out  8*NUM_CTRL  control register contents, CTRL0 in [7:0]
//  status_i   in   8           asynchronous status levels
//  event_i    in   1           clk-domain single-cycle event pulse
//  irq_o      out  1           registered interrupt, = |(IRQ_FLAG & IRQ_MASK)
//  wr_strobe  out  1           one-cycle pulse per committed write
// BEHAVIOUR
//  Async reset (rst_n=0): ctrl_o={NUM_CTRL{CTRL_RST}}; rd_data=0; irq_o=0; wr_strobe=0; mask/flags/counter/shadow=0;
//  status sync flops=0. Reset mid-transaction aborts; no partial write survives.
//  Write commit: wr_rise = writeEn & ~writeEn_q & iic_en. Register updated on that edge; wr_strobe high the
//  following cycle only. Held writeEn commits exactly once; writeEn rising while iic_en=0 is dropped.
//  Read: rd_data <= mux(regAddr) every cycle (1-cycle latency), 0 when iic_en=0. rd_rise = readEn & ~readEn_q & iic_en.
//  Map: 0x00..NUM_CTRL-1 CTRLn RW | 0x10 STATUS RO (synced status) | 0x11 IRQ_FLAG W1C | 0x12 IRQ_MASK RW |
//  0x14 CNT_LO | 0x15 CNT_HI (shadow) | 0x1E LOCK (see CONFIGURATION) | 0x1F ID RO. Unmapped: read 0x00, writes ignored.
//  status_i: 2-flop synchroniser, then rising-edge detect per bit sets IRQ_FLAG bit.
//  IRQ_FLAG: write clears bits where wr_data=1; set and clear same cycle -> set wins.
//  irq_o registered: asserts 1 cycle after flag or mask change makes (flag&mask)!=0.
//  Counter: 16-bit, +1 per event_i, wraps 0xFFFF->0x0000. Any write to 0x14 clears counter and shadow;
//  clear and event same cycle -> clear wins (result 0).
//  Atomic read: rd_rise with regAddr=0x14 latches counter[15:8] into shadow; 0x15 returns shadow, never live.
//  CNT_LO read reflects live counter[7:0] via the normal 1-cycle mux.
//  Simultaneous wr_rise and rd_rise on same address: write commits; rd_data shows new value next cycle.
// CONFIGURATION
//  IIC_REG_LOCK_EN defined: 0x1E LOCK RW, reset 0x00. CTRLn writes commit only when LOCK==8'hA5; rejected
//   writes produce no wr_strobe. LOCK, IRQ_MASK, IRQ_FLAG, 0x14 remain writable.
//  Not defined: 0x1E unmapped (reads 0x00); CTRLn always writable.
// TESTING
//  1 Reset: rst_n=0 mid-write -> ctrl_o all CTRL_RST, rd_data=0, irq_o=0; release, read 0x1F -> 0x5A.
//  2 Write 0x3C to 0x02 with writeEn held 5 cycles -> CTRL2=0x3C, exactly one wr_strobe; iic_en=0 write -> ignored.
//  3 status_i[3] 0->1, mask=0x08 -> IRQ_FLAG=0x08, irq_o=1; write 0x08 to 0x11 -> flag 0, irq_o=0; edge+clear same cycle -> flag stays 1.
//  4 300 event_i pulses -> read 0x14=0x2C, 0x15=0x01; 20 more events between reads -> 0x15 still 0x01.
//  5 Counter at 0xFFFF + event -> 0x0000; write 0x14 with event same cycle -> 0x0000.
//  6 IIC_REG_LOCK_EN: write CTRL0=0x11 with LOCK=0 -> unchanged, no strobe; LOCK=0xA5 then write -> CTRL0=0x11.

Source files
------------

// File: rtl/iic_reg_bank_if.sv
// Byte-wide register access bus between the IIC slave front end and its register bank.
// The slave front end is the master of this bus; the register bank is the slave.
interface iic_reg_bank_if;
    logic       iic_en;
    logic       writeEn;
    logic       readEn;
    logic [7:0] regAddr;
    logic [7:0] wr_data;
    logic [7:0] rd_data;
    logic       wr_strobe;

    modport master (
        output iic_en, writeEn, readEn, regAddr, wr_data,
        input  rd_data, wr_strobe
    );

    modport slave (
        input  iic_en, writeEn, readEn, regAddr, wr_data,
        output rd_data, wr_strobe
    );
endinterface

// File: rtl/iic_reg_bank.sv
// IIC register bank: control registers, synced status with IRQ flag/mask, and a 16-bit event counter
// with an atomic two-byte read. Define IIC_REG_LOCK_EN to add the 0x1E LOCK register guarding CTRLn writes.
module iic_reg_bank #(
    parameter int         NUM_CTRL = 8,
    parameter logic [7:0] CTRL_RST = 8'h00,
    parameter logic [7:0] ID_VALUE = 8'h5A
) (
    input  logic                  clk,
    input  logic                  rst_n,
    iic_reg_bank_if.slave         bus,
    output logic [8*NUM_CTRL-1:0] ctrl_o,
    input  logic [7:0]            status_i,
    input  logic                  event_i,
    output logic                  irq_o
);

    localparam logic [7:0] ADDR_STATUS = 8'h10;
    localparam logic [7:0] ADDR_FLAG   = 8'h11;
    localparam logic [7:0] ADDR_MASK   = 8'h12;
    localparam logic [7:0] ADDR_CNTLO  = 8'h14;
    localparam logic [7:0] ADDR_CNTHI  = 8'h15;
    localparam logic [7:0] ADDR_LOCK   = 8'h1E;
    localparam logic [7:0] ADDR_ID     = 8'h1F;

    logic        writeEnQ;
    logic        readEnQ;
    logic        wrRise;
    logic        rdRise;
    logic        ctrlWrOk;
    logic        wrAccepted;
    logic [NUM_CTRL-1:0] ctrlWr;
    logic [7:0]  ctrlArr [NUM_CTRL];

    logic [7:0]  statusMeta;
    logic [7:0]  statusSync;
    logic [7:0]  statusDly;
    logic [7:0]  statusRise;
    logic [7:0]  irqFlag;
    logic [7:0]  irqFlagNext;
    logic [7:0]  irqMask;
    logic [15:0] counter;
    logic [7:0]  cntShadow;
    logic        cntClr;

    logic [7:0]  rdMux;
    logic [7:0]  rdDataReg;
    logic        wrStrobeReg;
    logic        irqReg;

    assign wrRise = bus.writeEn & ~writeEnQ & bus.iic_en;
    assign rdRise = bus.readEn & ~readEnQ & bus.iic_en;

    // Edge flops reset high so a request still asserted when reset releases does not commit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            writeEnQ <= 1'b1;
            readEnQ  <= 1'b1;
        end else begin
            writeEnQ <= bus.writeEn;
            readEnQ  <= bus.readEn;
        end
    end

`ifdef IIC_REG_LOCK_EN
    logic [7:0] lockReg;
    logic       lockWr;

    assign lockWr   = wrRise & (bus.regAddr == ADDR_LOCK);
    assign ctrlWrOk = (lockReg == 8'hA5);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lockReg <= 8'h00;
        end else if (lockWr) begin
            lockReg <= bus.wr_data;
        end
    end
`else
    logic lockWr;

    assign lockWr   = 1'b0;
    assign ctrlWrOk = 1'b1;
`endif

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CTRL; gi++) begin : gCtrl
            logic [7:0] ctrlReg;

            assign ctrlWr[gi] = wrRise & ctrlWrOk & (bus.regAddr == 8'(gi));

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    ctrlReg <= CTRL_RST;
                end else if (ctrlWr[gi]) begin
                    ctrlReg <= bus.wr_data;
                end
            end

            assign ctrlArr[gi]         = ctrlReg;
            assign ctrl_o[gi*8 +: 8]   = ctrlReg;
        end
    endgenerate

    assign cntClr     = wrRise & (bus.regAddr == ADDR_CNTLO);
    assign statusRise = statusSync & ~statusDly;
    assign wrAccepted = (|ctrlWr) | cntClr | lockWr |
                        (wrRise & ((bus.regAddr == ADDR_FLAG) | (bus.regAddr == ADDR_MASK)));

    // W1C clear is applied first so a coincident status edge keeps its flag set.
    always_comb begin
        irqFlagNext = irqFlag;
        if (wrRise && (bus.regAddr == ADDR_FLAG)) begin
            irqFlagNext = irqFlagNext & ~bus.wr_data;
        end
        irqFlagNext = irqFlagNext | statusRise;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            statusMeta <= 8'h00;
            statusSync <= 8'h00;
            statusDly  <= 8'h00;
            irqFlag    <= 8'h00;
            irqMask    <= 8'h00;
            irqReg     <= 1'b0;
        end else begin
            statusMeta <= status_i;
            statusSync <= statusMeta;
            statusDly  <= statusSync;
            irqFlag    <= irqFlagNext;
            if (wrRise && (bus.regAddr == ADDR_MASK)) begin
                irqMask <= bus.wr_data;
            end
            irqReg <= |(irqFlag & irqMask);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            counter   <= 16'h0000;
            cntShadow <= 8'h00;
        end else if (cntClr) begin
            counter   <= 16'h0000;
            cntShadow <= 8'h00;
        end else begin
            if (event_i) begin
                counter <= counter + 16'd1;
            end
            if (rdRise && (bus.regAddr == ADDR_CNTLO)) begin
                cntShadow <= counter[15:8];
            end
        end
    end

    always_comb begin
        rdMux = 8'h00;
        for (int i = 0; i < NUM_CTRL; i++) begin
            if (bus.regAddr == 8'(i)) begin
                rdMux = ctrlArr[i];
            end
        end
        case (bus.regAddr)
            ADDR_STATUS: rdMux = statusSync;
            ADDR_FLAG:   rdMux = irqFlag;
            ADDR_MASK:   rdMux = irqMask;
            ADDR_CNTLO:  rdMux = counter[7:0];
            ADDR_CNTHI:  rdMux = cntShadow;
`ifdef IIC_REG_LOCK_EN
            ADDR_LOCK:   rdMux = lockReg;
`endif
            ADDR_ID:     rdMux = ID_VALUE;
            default:     ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdDataReg   <= 8'h00;
            wrStrobeReg <= 1'b0;
        end else begin
            rdDataReg   <= bus.iic_en ? rdMux : 8'h00;
            wrStrobeReg <= wrAccepted;
        end
    end

    assign bus.rd_data   = rdDataReg;
    assign bus.wr_strobe = wrStrobeReg;
    assign irq_o         = irqReg;

endmodule

// File: tb/tb_iic_reg_bank.sv
// Self-checking bench for iic_reg_bank: table of register accesses plus hand-written sequences
// for reset, held writes, IRQ set/clear races and the counter's atomic read and wrap.
module tb_iic_reg_bank;

    localparam int NC = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [8*NC-1:0] ctrl_o;
    logic [7:0]    status_i;
    logic          event_i;
    logic          irq_o;

    always #5 clk = ~clk;

    iic_reg_bank_if bus();

    iic_reg_bank #(.NUM_CTRL(NC), .CTRL_RST(8'h00), .ID_VALUE(8'h5A)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus.slave),
        .ctrl_o   (ctrl_o),
        .status_i (status_i),
        .event_i  (event_i),
        .irq_o    (irq_o)
    );

    typedef struct {
        logic [7:0] addr;
        logic [7:0] data;
        bit         isWr;
        int         expStrobe;
        string      name;
    } vec_t;

    int         vecCnt = 0;
    int         errCnt = 0;
    int         strobeCnt = 0;
    logic [7:0] expQ [$];
    logic [7:0] ctrlModel [NC];
    logic [7:0] lockModel = 8'h00;
    vec_t       vecs [16];
    int         nVecs;

    always @(negedge clk) begin
        if (bus.wr_strobe) strobeCnt++;
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vecCnt++;
        if (act !== exp) begin
            errCnt++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end else begin
            $display("ok   %s: %0h", nm, act);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkCtrl(input string nm);
        logic [8*NC-1:0] exp;
        for (int i = 0; i < NC; i++) exp[i*8 +: 8] = ctrlModel[i];
        check(nm, 64'(ctrl_o), 64'(exp));
    endtask

    task automatic doWrite(input logic [7:0] addr, input logic [7:0] data, input int hold);
        bit ctrlOk;
        ctrlOk = 1'b1;
`ifdef IIC_REG_LOCK_EN
        ctrlOk = (lockModel == 8'hA5);
        if (addr == 8'h1E) lockModel = data;
`endif
        if (addr < 8'(NC) && ctrlOk) ctrlModel[addr[3:0]] = data;
        bus.regAddr = addr;
        bus.wr_data = data;
        bus.iic_en  = 1'b1;
        bus.writeEn = 1'b1;
        repeat (hold) tick();
        bus.writeEn = 1'b0;
        tick();
    endtask

    task automatic doRead(input logic [7:0] addr, input logic [7:0] exp, input string nm);
        bus.regAddr = addr;
        bus.iic_en  = 1'b1;
        bus.readEn  = 1'b1;
        expQ.push_back(exp);
        tick();
        check(nm, 64'(bus.rd_data), 64'(expQ.pop_front()));
        bus.readEn = 1'b0;
        tick();
    endtask

    task automatic pulses(input int n);
        repeat (n) begin
            event_i = 1'b1;
            tick();
            event_i = 1'b0;
            tick();
        end
    endtask

    initial begin
        int s;
        for (int i = 0; i < NC; i++) ctrlModel[i] = 8'h00;
        bus.iic_en  = 1'b1;
        bus.writeEn = 1'b1;
        bus.readEn  = 1'b0;
        bus.regAddr = 8'h02;
        bus.wr_data = 8'hAA;
        status_i    = 8'h00;
        event_i     = 1'b0;

        // Reset held while a write is being presented.
        #22;
        checkCtrl("rst_ctrl");
        check("rst_rd_data", 64'(bus.rd_data), 64'h0);
        check("rst_irq", 64'(irq_o), 64'h0);
        bus.writeEn = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        checkCtrl("rst_release_ctrl");
        doRead(8'h1F, 8'h5A, "id_after_reset");

`ifdef IIC_REG_LOCK_EN
        doWrite(8'h1E, 8'h00, 1);
        s = strobeCnt;
        doWrite(8'h00, 8'h11, 1);
        check("locked_no_strobe", 64'(strobeCnt - s), 64'd0);
        checkCtrl("locked_ctrl0");
        doWrite(8'h1E, 8'hA5, 1);
        s = strobeCnt;
        doWrite(8'h00, 8'h11, 1);
        check("unlocked_strobe", 64'(strobeCnt - s), 64'd1);
        checkCtrl("unlocked_ctrl0");
`endif

        vecs[0]  = '{8'h00, 8'h00, 1'b0, 0, "rd_ctrl0"};
        vecs[1]  = '{8'h01, 8'hA7, 1'b1, 1, "wr_ctrl1"};
        vecs[2]  = '{8'h01, 8'hA7, 1'b0, 0, "rd_ctrl1"};
        vecs[3]  = '{8'h07, 8'hFF, 1'b1, 1, "wr_ctrl7"};
        vecs[4]  = '{8'h07, 8'hFF, 1'b0, 0, "rd_ctrl7"};
        vecs[5]  = '{8'h08, 8'h55, 1'b1, 0, "wr_unmapped08"};
        vecs[6]  = '{8'h08, 8'h00, 1'b0, 0, "rd_unmapped08"};
        vecs[7]  = '{8'h12, 8'h08, 1'b1, 1, "wr_mask"};
        vecs[8]  = '{8'h12, 8'h08, 1'b0, 0, "rd_mask"};
`ifdef IIC_REG_LOCK_EN
        vecs[9]  = '{8'h1E, 8'hA5, 1'b0, 0, "rd_lock"};
`else
        vecs[9]  = '{8'h1E, 8'h00, 1'b0, 0, "rd_lock_unmapped"};
`endif
        vecs[10] = '{8'h10, 8'h00, 1'b0, 0, "rd_status"};
        vecs[11] = '{8'h1F, 8'h00, 1'b1, 0, "wr_id_ro"};
        vecs[12] = '{8'h1F, 8'h5A, 1'b0, 0, "rd_id"};
        vecs[13] = '{8'h13, 8'h00, 1'b0, 0, "rd_unmapped13"};
        vecs[14] = '{8'h15, 8'h00, 1'b0, 0, "rd_cnthi_reset"};
        nVecs = 15;

        for (int v = 0; v < nVecs; v++) begin
            if (vecs[v].isWr) begin
                s = strobeCnt;
                doWrite(vecs[v].addr, vecs[v].data, 1);
                check({vecs[v].name, "_strobe"}, 64'(strobeCnt - s), 64'(vecs[v].expStrobe));
                checkCtrl({vecs[v].name, "_ctrl"});
            end else begin
                doRead(vecs[v].addr, vecs[v].data, vecs[v].name);
            end
        end

        // Held write commits once; write with iic_en low is dropped.
        s = strobeCnt;
        doWrite(8'h02, 8'h3C, 5);
        check("held_write_strobe", 64'(strobeCnt - s), 64'd1);
        checkCtrl("held_write_ctrl2");
        s = strobeCnt;
        bus.iic_en  = 1'b0;
        bus.regAddr = 8'h02;
        bus.wr_data = 8'h77;
        bus.writeEn = 1'b1;
        tick();
        tick();
        check("iic_off_rd_zero", 64'(bus.rd_data), 64'h0);
        bus.writeEn = 1'b0;
        tick();
        check("iic_off_strobe", 64'(strobeCnt - s), 64'd0);
        checkCtrl("iic_off_ctrl2");

        // Same-address write and read rising together.
        bus.iic_en  = 1'b1;
        bus.regAddr = 8'h03;
        bus.wr_data = 8'h9E;
        bus.writeEn = 1'b1;
        bus.readEn  = 1'b1;
        ctrlModel[3] = 8'h9E;
        expQ.push_back(8'h9E);
        tick();
        bus.writeEn = 1'b0;
        bus.readEn  = 1'b0;
        tick();
        check("wr_rd_same_addr", 64'(bus.rd_data), 64'(expQ.pop_front()));
        checkCtrl("wr_rd_same_ctrl");

        // Status edge sets flag; mask and W1C drive irq_o.
        status_i = 8'h08;
        repeat (5) tick();
        doRead(8'h11, 8'h08, "flag_set");
        check("irq_on", 64'(irq_o), 64'h1);
        doRead(8'h10, 8'h08, "rd_status_sync");
        doWrite(8'h12, 8'h00, 1);
        check("irq_masked", 64'(irq_o), 64'h0);
        doWrite(8'h12, 8'h08, 1);
        check("irq_unmasked", 64'(irq_o), 64'h1);
        doWrite(8'h11, 8'h08, 1);
        check("irq_cleared", 64'(irq_o), 64'h0);
        doRead(8'h11, 8'h00, "flag_cleared");
        status_i = 8'h00;
        repeat (4) tick();
        status_i = 8'h08;
        tick();
        tick();
        bus.regAddr = 8'h11;
        bus.wr_data = 8'h08;
        bus.writeEn = 1'b1;
        tick();
        bus.writeEn = 1'b0;
        tick();
        doRead(8'h11, 8'h08, "flag_set_wins");
        doWrite(8'h11, 8'hFF, 1);
        doWrite(8'h12, 8'h00, 1);

        // Counter atomic read.
        doWrite(8'h14, 8'h00, 1);
        pulses(300);
        doRead(8'h14, 8'h2C, "cnt300_lo");
        pulses(20);
        doRead(8'h15, 8'h01, "cnt_hi_shadow");
        doRead(8'h14, 8'h40, "cnt320_lo");
        doRead(8'h15, 8'h01, "cnt320_hi");

        // Wrap at 0xFFFF.
        doWrite(8'h14, 8'h00, 1);
        event_i = 1'b1;
        repeat (65535) tick();
        event_i = 1'b0;
        doRead(8'h14, 8'hFF, "cnt_ffff_lo");
        doRead(8'h15, 8'hFF, "cnt_ffff_hi");
        pulses(1);
        doRead(8'h14, 8'h00, "cnt_wrap_lo");
        doRead(8'h15, 8'h00, "cnt_wrap_hi");

        // Clear and event in the same cycle.
        pulses(260);
        doRead(8'h14, 8'h04, "cnt260_lo");
        doRead(8'h15, 8'h01, "cnt260_hi");
        bus.regAddr = 8'h14;
        bus.wr_data = 8'h00;
        bus.writeEn = 1'b1;
        event_i     = 1'b1;
        tick();
        bus.writeEn = 1'b0;
        event_i     = 1'b0;
        tick();
        doRead(8'h15, 8'h00, "clr_wins_hi");
        doRead(8'h14, 8'h00, "clr_wins_lo");

        // Reset asserted mid-write aborts it.
        bus.regAddr = 8'h05;
        bus.wr_data = 8'h66;
        bus.writeEn = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < NC; i++) ctrlModel[i] = 8'h00;
        lockModel = 8'h00;
        checkCtrl("midrst_ctrl");
        check("midrst_rd_data", 64'(bus.rd_data), 64'h0);
        check("midrst_irq", 64'(irq_o), 64'h0);
        tick();
        bus.writeEn = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        doRead(8'h1F, 8'h5A, "midrst_id");
        doRead(8'h05, 8'h00, "midrst_ctrl5");
        checkCtrl("midrst_final_ctrl");

        $display("== %0d vectors applied, %0d miscompares ==", vecCnt, errCnt);
        $finish;
    end

endmodule
